// File: rtl/sha3_theta_elts_acc.sv
// rtl/sha3_theta_elts_acc.sv - Keccak theta-element generator with row-beat parity accumulation and registered output
module sha3_theta_elts_acc #(
    parameter int W         = 64,
    parameter int BEAT_ROWS = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BEAT_ROWS-1:0][4:0][W-1:0]  irow,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [4:0][W-1:0]                 oelt
);

    localparam int BEATS = 5 / BEAT_ROWS;

    logic [2:0]           cnt;
    logic [4:0][W-1:0]    acc;
    logic [4:0][W-1:0]    term;
    logic                 term_valid;
    logic [4:0][W-1:0]    beat_par;
    logic [4:0][W-1:0]    acc_next;
    logic [4:0][W-1:0]    theta;
    logic                 s2_free;
    logic                 accept;
    logic                 last_beat;

    function automatic logic [W-1:0] rotl1(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = v[(i + W - 1) % W];
        end
        return r;
    endfunction

    always_comb begin
        beat_par = '0;
        for (int x = 0; x < 5; x++) begin
            for (int r = 0; r < BEAT_ROWS; r++) begin
                beat_par[x] = beat_par[x] ^ irow[r][x];
            end
        end
    end

    // The first beat of a state overwrites acc, so no explicit clear of acc is needed between states.
    always_comb begin
        acc_next = '0;
        for (int x = 0; x < 5; x++) begin
            acc_next[x] = (cnt == 3'd0) ? beat_par[x] : (acc[x] ^ beat_par[x]);
        end
    end

    always_comb begin
        theta = '0;
        for (int x = 0; x < 5; x++) begin
            theta[x] = term[(x + 4) % 5] ^ rotl1(term[(x + 1) % 5]);
        end
    end

    assign s2_free   = !out_valid || out_ready;
    assign in_ready  = !term_valid || s2_free;
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == 3'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 3'd0;
            acc        <= '0;
            term       <= '0;
            term_valid <= 1'b0;
            out_valid  <= 1'b0;
            oelt       <= '0;
        end else if (clear) begin
            cnt        <= 3'd0;
            term_valid <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (term_valid && s2_free) begin
                oelt      <= theta;
                out_valid <= 1'b1;
            end else if (s2_free) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                acc <= acc_next;
                if (last_beat) begin
                    term <= acc_next;
                    cnt  <= 3'd0;
                end else begin
                    cnt  <= cnt + 3'd1;
                end
            end

            // A fresh term may load in the same cycle the old one moves to oelt.
            if (accept && last_beat) begin
                term_valid <= 1'b1;
            end else if (term_valid && s2_free) begin
                term_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sha3_theta_elts_acc.md
# sha3_theta_elts_acc

Parametrised theta-element generator for the Keccak-f permutation core. Accepts the 5x5 lane state as one or more row-beats over a valid/ready handshake, accumulates the five column parities C[x], then emits the five theta elements D[x] = C[x-1] ^ rotl(C[x+1], 1) through a registered, back-pressurable output. It generalises the fixed 64-bit, single-beat theta-elts stage to any power-of-two lane width and to row-serial input, and adds flow control and flush.

## Interface
- W, 64, lane width in bits; legal 1, 2, 4, 8, 16, 32, 64 (Keccak-f[25*W]).
- BEAT_ROWS, 5, rows of lanes carried per input beat; legal 1 or 5. BEATS = 5 / BEAT_ROWS beats per state.

Ports: clock `clk`, single clock domain; reset `rst`, asynchronous, active-high.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous flush; discards partial accumulation and all pipeline contents.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- irow  in  [BEAT_ROWS][5] x W  lanes irow[r][x]; row r of the beat, column x.
- out_valid  out  1  oelt holds a valid theta-element set.
- out_ready  in  1  consumer takes oelt this cycle.
- oelt  out  [5] x W  theta elements D[0..4].

## Operation
- Beat accepted when in_valid && in_ready. beat_par[x] = XOR over r of irow[r][x].
- Beat counter cnt, log2 range 0..BEATS-1 (absent/constant 0 when BEATS=1).
- On accepted beat with cnt==0: acc[x] <= beat_par[x]. Otherwise acc[x] <= acc[x] ^ beat_par[x].
- On accepted beat with cnt==BEATS-1: term[x] <= (cnt==0 ? beat_par[x] : acc[x] ^ beat_par[x]); term_valid <= 1; cnt <= 0. Otherwise cnt <= cnt+1.
- s2_free = !out_valid || out_ready.
- When term_valid && s2_free: oelt[x] <= term[(x+4)%5] ^ rotl(term[(x+1)%5], 1), rotation modulo W (bit W-1 wraps to bit 0); out_valid <= 1; term_valid cleared unless reloaded same cycle.
- When out_valid && out_ready and no new term moves in: out_valid <= 0; oelt holds its last value.
- in_ready = !term_valid || s2_free (combinational; uniform for all beats).
- clear: cnt <= 0, term_valid <= 0, out_valid <= 0; beat presented in the same cycle is dropped; acc/term/oelt data retain values (don't-care). clear has priority over every other update.
- Reset values: cnt=0, acc=0, term=0, term_valid=0, out_valid=0, oelt=0; in_ready=1 once rst is low.
- Reset mid-accumulation: partial state lost; next accepted beat is row-beat 0 of a new state.

## Timing
- BEAT_ROWS=5: state accepted at edge n -> term at n+1 -> oelt/out_valid visible after edge n+2. Latency 2 cycles; throughput one state per cycle with out_ready held high.
- BEAT_ROWS=1: last (5th) beat at edge n -> oelt after edge n+2; one state per 5 accepted beats.
- Stalls: out_valid && !out_ready with term_valid -> in_ready=0; oelt and term frozen; no data lost or duplicated.
- Gaps in in_valid between beats of one state are legal; cnt holds.
- No combinational path from in_valid or irow to outputs; only out_ready -> in_ready is combinational.

## Test plan
- All-zero state, W=64, BEAT_ROWS=5 -> after 2 cycles out_valid=1, all oelt=0; after reset all outputs 0, in_ready=1.
- Single bit: lane (x=0,y=0)=1 -> oelt[1]=0x1, oelt[4]=0x2, others 0; lane (0,0)=2^63 -> oelt[1]=2^63, oelt[4]=0x1 (wrap).
- W=8, BEAT_ROWS=1, lane (2,3)=0x80, other rows zero, five beats with random in_valid gaps -> oelt[3]=0x80, oelt[1]=0x01, others 0; exactly one out_valid pulse.
- Back-to-back random states with random out_ready -> every state yields exactly one oelt matching a software theta model, in order; in_ready low only when term_valid && out_valid && !out_ready.
- BEAT_ROWS=1: clear after 3 beats, then 5 fresh beats -> output equals model of fresh beats only; rst asserted mid-state gives the same result.
- clear while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, in_ready=1, no output for flushed state.
